i2s_clkws_monitor: RTL and testbench
====================================

Name: i2s_clkws_monitor

Overview:
Single-clock monitor for an externally driven I2S bit clock and word select, i.e. the receiving end of a SCK/WS generator pair. It oversamples pad SCK and WS with the system clock and measures the SCK period in clk_i cycles and the WS phase length in SCK cycles. It declares lock once the frame timing is stable and flags mismatches and clock loss. Sits beside the I2S slave path when the slave channel is selected as externally clocked; results go to uDMA config registers and event lines.

Parameters:
CNT_W, 16, width of SCK period counter and timeout compare
BIT_W, 8, width of WS phase-length counter
LOCK_PHASES, 4, consecutive equal-length WS phases required for lock (>=2)

Ports:
clk_i  in  1  system clock
rstn_i  in  1  asynchronous active-low reset
en_i  in  1  monitor enable; low forces IDLE
sck_i  in  1  asynchronous pad SCK
ws_i  in  1  asynchronous pad WS
cfg_timeout_i  in  CNT_W  clk cycles without an SCK rising edge before clock loss is declared; 0 disables timeout
clr_err_i  in  1  pulse, clears sticky error flags
sck_period_o  out  CNT_W  clk cycles between the last two SCK rising edges, saturating
phase_len_o  out  BIT_W  locked WS phase length in SCK cycles
locked_o  out  1  frame timing locked
frame_evt_o  out  1  one-cycle pulse on WS rising edge while locked
err_mismatch_o  out  1  sticky, phase length changed while locked
err_timeout_o  out  1  sticky, SCK lost while locked

Behaviour:
- All outputs reset to 0. All state returns to reset values asynchronously on rstn_i low.
- sck_i and ws_i each pass through a 2-flop synchronizer plus one history flop. An SCK rising edge (sck_re) is synced=1 and history=0. Valid for SCK <= clk_i/4.
- Period counter: increments every clk cycle and saturates at all-ones. On sck_re, its value +1 loads sck_period_o and the counter clears. sck_period_o is not updated before the second sck_re after leaving IDLE.
- WS sampling: synced WS is captured only on sck_re (ws_s). ws_chg = sck_re and synced WS != ws_s.
- Bit counter: on sck_re without ws_chg, increment, saturating at all-ones. On ws_chg, the value +1 is the measured length (meas_len) and the counter clears.
- Saturation of the bit counter in LOCKED counts as a mismatch.
- Timeout: cfg_timeout_i != 0 and period counter >= cfg_timeout_i -> tmo. tmo takes priority over a coincident ws_chg.
- FSM:
  - IDLE: entered when en_i=0, from any state, with a 1-cycle effect. Counters clear and locked_o=0. Goes to SEARCH when en_i=1.
  - SEARCH: the first ws_chg discards the partial phase and moves to MEASURE.
  - MEASURE: on ws_chg, ref_len=meas_len, match=1, go to VERIFY.
  - VERIFY: on ws_chg, if meas_len==ref_len then match++. When match reaches LOCK_PHASES, go to LOCKED with phase_len_o=ref_len and locked_o=1 on the next cycle. If meas_len differs, ref_len=meas_len and match=1.
  - LOCKED: on ws_chg with a different length, set err_mismatch_o, clear locked_o, ref_len=meas_len, match=1, go to VERIFY. On tmo, set err_timeout_o, clear locked_o, go to SEARCH.
  - tmo in MEASURE or VERIFY goes to SEARCH with no error.
- frame_evt_o pulses 1 cycle after a ws_chg to 1 while in LOCKED, including the transition edge into LOCKED if WS rose.
- clr_err_i clears both sticky flags. If a set and a clear occur in the same cycle, the set wins.
- phase_len_o holds its last locked value after lock loss.

Decomposition:
- Package i2s_mon_pkg: FSM state enum (IDLE, SEARCH, MEASURE, VERIFY, LOCKED) and default parameter constants.
- One sub-module, i2s_edge_sync: a 2-flop synchronizer plus history flop with a rise-pulse output, instantiated for sck and ws. Reuse pulp_sync for the flops.

Test Plan:
- SCK period 8 clk, 16-bit WS phases, cfg_timeout_i=64 -> sck_period_o=8, phase_len_o=16, locked_o=1 about 3 cycles after the 5th WS edge, frame_evt_o once per 32 SCK.
- Locked at 16, then one 24-bit phase -> err_mismatch_o=1 and locked_o=0. Relock after four 24-bit phases with phase_len_o=24.
- Locked, then stop SCK, cfg_timeout_i=64 -> err_timeout_o=1 and locked_o=0 64 cycles after the last edge. Restart SCK -> relock. Pulse clr_err_i -> flags 0.
- Phases alternating 16/17 -> locked_o never asserts and no errors.
- Deassert en_i or rstn_i mid-VERIFY -> all outputs 0. Re-enable with 32-bit phases -> lock with phase_len_o=32.
- cfg_timeout_i=0, SCK stopped 70000 cycles -> sck_period_o saturates at 0xFFFF on the next edge, no timeout error.

Source files
------------

// File: rtl/i2s_mon_pkg.sv
// Shared types and default constants for the I2S SCK/WS timing monitor.
package i2s_mon_pkg;

    localparam int CNT_W_DEF       = 16;
    localparam int BIT_W_DEF       = 8;
    localparam int LOCK_PHASES_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        MEASURE,
        VERIFY,
        LOCKED
    } mon_state_e;

endpackage

// File: rtl/i2s_edge_sync.sv
// Two-flop synchronizer for an asynchronous pad input, plus a history flop
// that yields a single-cycle rising-edge pulse in the clk_i domain.
module i2s_edge_sync
    import i2s_mon_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_sync,
    output logic o_rise
);

    logic [1:0] r_sync;
    logic       r_hist;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_d};
            r_hist <= r_sync[1];
        end
    end

    assign o_sync = r_sync[1];
    assign o_rise = r_sync[1] & ~r_hist;

endmodule

// File: rtl/i2s_clkws_monitor.sv
// Measures external I2S SCK period and WS phase length, declares lock once
// the frame timing repeats, and flags length mismatches and SCK loss.
module i2s_clkws_monitor
    import i2s_mon_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int BIT_W       = BIT_W_DEF,
    parameter int LOCK_PHASES = LOCK_PHASES_DEF
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             en_i,
    input  logic             sck_i,
    input  logic             ws_i,
    input  logic [CNT_W-1:0] cfg_timeout_i,
    input  logic             clr_err_i,
    output logic [CNT_W-1:0] sck_period_o,
    output logic [BIT_W-1:0] phase_len_o,
    output logic             locked_o,
    output logic             frame_evt_o,
    output logic             err_mismatch_o,
    output logic             err_timeout_o
);

    localparam int MATCH_W = $clog2(LOCK_PHASES + 1);

    logic w_sck_sync_unused, w_sck_re;
    logic w_ws_sync, w_ws_rise_unused;

    mon_state_e r_state, w_state_nxt;

    logic [CNT_W-1:0]   r_per_cnt, w_per_meas;
    logic               r_per_seen;
    logic [BIT_W-1:0]   r_bit_cnt, r_ref_len, w_meas_len;
    logic [MATCH_W-1:0] r_match, w_match_inc;
    logic               r_ws_s;
    logic               w_ws_chg, w_tmo, w_bit_sat, w_clear;
    logic               w_ref_load, w_match_up, w_set_mm, w_set_tmo;

    i2s_edge_sync u_sck_sync (
        .i_clk   (clk_i),
        .i_rst_n (rstn_i),
        .i_d     (sck_i),
        .o_sync  (w_sck_sync_unused),
        .o_rise  (w_sck_re)
    );

    i2s_edge_sync u_ws_sync (
        .i_clk   (clk_i),
        .i_rst_n (rstn_i),
        .i_d     (ws_i),
        .o_sync  (w_ws_sync),
        .o_rise  (w_ws_rise_unused)
    );

    assign w_ws_chg    = w_sck_re && (w_ws_sync != r_ws_s);
    assign w_bit_sat   = &r_bit_cnt;
    assign w_meas_len  = w_bit_sat ? r_bit_cnt : r_bit_cnt + BIT_W'(1);
    assign w_per_meas  = (&r_per_cnt) ? r_per_cnt : r_per_cnt + CNT_W'(1);
    assign w_tmo       = (cfg_timeout_i != '0) && (r_per_cnt >= cfg_timeout_i);
    assign w_match_inc = r_match + MATCH_W'(1);
    assign w_clear     = !en_i || (r_state == IDLE);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Timeout outranks a coincident WS change in every measuring state.
    always_comb begin
        w_state_nxt = r_state;
        w_ref_load  = 1'b0;
        w_match_up  = 1'b0;
        w_set_mm    = 1'b0;
        w_set_tmo   = 1'b0;
        if (!en_i) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: w_state_nxt = SEARCH;
                SEARCH: begin
                    if (!w_tmo && w_ws_chg) w_state_nxt = MEASURE;
                end
                MEASURE: begin
                    if (w_tmo) begin
                        w_state_nxt = SEARCH;
                    end else if (w_ws_chg) begin
                        w_ref_load  = 1'b1;
                        w_state_nxt = VERIFY;
                    end
                end
                VERIFY: begin
                    if (w_tmo) begin
                        w_state_nxt = SEARCH;
                    end else if (w_ws_chg) begin
                        if (w_meas_len == r_ref_len) begin
                            w_match_up = 1'b1;
                            if (w_match_inc == MATCH_W'(LOCK_PHASES)) w_state_nxt = LOCKED;
                        end else begin
                            w_ref_load = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (w_tmo) begin
                        w_set_tmo   = 1'b1;
                        w_state_nxt = SEARCH;
                    end else if ((w_ws_chg && (w_meas_len != r_ref_len)) ||
                                 (w_sck_re && !w_ws_chg && w_bit_sat)) begin
                        w_set_mm    = 1'b1;
                        w_ref_load  = 1'b1;
                        w_state_nxt = VERIFY;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_per_cnt      <= '0;
            r_per_seen     <= 1'b0;
            r_bit_cnt      <= '0;
            r_ref_len      <= '0;
            r_match        <= '0;
            r_ws_s         <= 1'b0;
            sck_period_o   <= '0;
            phase_len_o    <= '0;
            locked_o       <= 1'b0;
            frame_evt_o    <= 1'b0;
            err_mismatch_o <= 1'b0;
            err_timeout_o  <= 1'b0;
        end else if (w_clear) begin
            r_per_cnt      <= '0;
            r_per_seen     <= 1'b0;
            r_bit_cnt      <= '0;
            r_ref_len      <= '0;
            r_match        <= '0;
            r_ws_s         <= 1'b0;
            sck_period_o   <= '0;
            phase_len_o    <= '0;
            locked_o       <= 1'b0;
            frame_evt_o    <= 1'b0;
            err_mismatch_o <= 1'b0;
            err_timeout_o  <= 1'b0;
        end else begin
            // The first edge after IDLE only starts the period count.
            if (w_sck_re) begin
                r_per_cnt  <= '0;
                r_per_seen <= 1'b1;
                r_ws_s     <= w_ws_sync;
                if (r_per_seen) sck_period_o <= w_per_meas;
            end else if (!(&r_per_cnt)) begin
                r_per_cnt <= r_per_cnt + CNT_W'(1);
            end

            if (w_ws_chg)                     r_bit_cnt <= '0;
            else if (w_sck_re && !w_bit_sat)  r_bit_cnt <= r_bit_cnt + BIT_W'(1);

            if (w_ref_load) begin
                r_ref_len <= w_meas_len;
                r_match   <= MATCH_W'(1);
            end else if (w_match_up) begin
                r_match <= w_match_inc;
            end

            locked_o    <= (w_state_nxt == LOCKED);
            frame_evt_o <= w_ws_chg && w_ws_sync && (w_state_nxt == LOCKED);
            if ((w_state_nxt == LOCKED) && (r_state != LOCKED)) phase_len_o <= r_ref_len;

            if (w_set_mm)       err_mismatch_o <= 1'b1;
            else if (clr_err_i) err_mismatch_o <= 1'b0;
            if (w_set_tmo)      err_timeout_o  <= 1'b1;
            else if (clr_err_i) err_timeout_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_clkws_monitor.sv
// Directed bench for i2s_clkws_monitor: drives SCK/WS frames and compares
// DUT outputs against expectations queued alongside the stimulus.
module tb_i2s_clkws_monitor;

    localparam int S_PER   = 0;
    localparam int S_PLEN  = 1;
    localparam int S_LOCK  = 2;
    localparam int S_MM    = 3;
    localparam int S_TMO   = 4;
    localparam int S_FEVT  = 5;
    localparam int S_NFR   = 6;
    localparam int S_NLOCK = 7;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        sck;
    logic        ws;
    logic [15:0] cfg_timeout;
    logic        clr_err;
    logic [15:0] sck_period_o;
    logic [7:0]  phase_len_o;
    logic        locked_o;
    logic        frame_evt_o;
    logic        err_mismatch_o;
    logic        err_timeout_o;

    typedef struct {
        string       tag;
        int          sel;
        int unsigned want;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_frames = 0;
    int   n_lock_cyc = 0;
    int   frame_base;
    int   lock_base;
    logic cur_ws;

    always #5 clk = ~clk;

    i2s_clkws_monitor dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .en_i           (en),
        .sck_i          (sck),
        .ws_i           (ws),
        .cfg_timeout_i  (cfg_timeout),
        .clr_err_i      (clr_err),
        .sck_period_o   (sck_period_o),
        .phase_len_o    (phase_len_o),
        .locked_o       (locked_o),
        .frame_evt_o    (frame_evt_o),
        .err_mismatch_o (err_mismatch_o),
        .err_timeout_o  (err_timeout_o)
    );

    always @(posedge clk) begin
        if (frame_evt_o) n_frames++;
        if (locked_o)    n_lock_cyc++;
    end

    function automatic int unsigned observe(input int sel);
        case (sel)
            S_PER:   return 32'(sck_period_o);
            S_PLEN:  return 32'(phase_len_o);
            S_LOCK:  return 32'(locked_o);
            S_MM:    return 32'(err_mismatch_o);
            S_TMO:   return 32'(err_timeout_o);
            S_FEVT:  return 32'(frame_evt_o);
            S_NFR:   return 32'(n_frames - frame_base);
            S_NLOCK: return 32'(n_lock_cyc - lock_base);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input int unsigned want);
        exp_t e;
        e.tag  = tag;
        e.sel  = sel;
        e.want = want;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        int unsigned obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            n_total++;
            assert (obs === e.want) begin
                n_pass++;
            end else begin
                $error("FAIL %s: observed 0x%0h, expected 0x%0h", e.tag, obs, e.want);
            end
        end
    endtask

    // One SCK bit, 8 clk long; WS changes while SCK is low.
    task automatic sck_bit(input logic ws_v);
        @(negedge clk);
        sck = 1'b0;
        ws  = ws_v;
        repeat (4) @(negedge clk);
        sck = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic phase(input int nbits);
        cur_ws = ~cur_ws;
        for (int i = 0; i < nbits; i++) sck_bit(cur_ws);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic expect_all_zero(input string pfx);
        expect_val({pfx, "_period"}, S_PER, 0);
        expect_val({pfx, "_plen"},   S_PLEN, 0);
        expect_val({pfx, "_locked"}, S_LOCK, 0);
        expect_val({pfx, "_fevt"},   S_FEVT, 0);
        expect_val({pfx, "_mm"},     S_MM, 0);
        expect_val({pfx, "_tmo"},    S_TMO, 0);
    endtask

    initial begin
        rstn        = 1'b0;
        en          = 1'b0;
        sck         = 1'b0;
        ws          = 1'b0;
        cur_ws      = 1'b1;
        cfg_timeout = 16'd64;
        clr_err     = 1'b0;
        frame_base  = 0;
        lock_base   = 0;

        // Reset state
        repeat (5) @(negedge clk);
        expect_all_zero("reset");
        drain();

        // Basic lock: 8-clk SCK, 16-bit phases
        rstn = 1'b1;
        @(negedge clk);
        en = 1'b1;
        repeat (3) @(negedge clk);
        frame_base = n_frames;
        for (int p = 0; p < 8; p++) phase(16);
        settle();
        expect_val("lock16_period", S_PER, 8);
        expect_val("lock16_plen", S_PLEN, 16);
        expect_val("lock16_locked", S_LOCK, 1);
        expect_val("lock16_frames", S_NFR, 2);
        expect_val("lock16_mm", S_MM, 0);
        drain();

        // One 24-bit phase breaks lock, then relock at 24
        phase(24);
        phase(24);
        settle();
        expect_val("mm_flag", S_MM, 1);
        expect_val("mm_unlocked", S_LOCK, 0);
        expect_val("mm_plen_hold", S_PLEN, 16);
        drain();
        for (int p = 0; p < 3; p++) phase(24);
        settle();
        expect_val("relock24_locked", S_LOCK, 1);
        expect_val("relock24_plen", S_PLEN, 24);
        expect_val("relock24_mm_sticky", S_MM, 1);
        drain();

        // SCK loss while locked
        @(negedge clk);
        sck = 1'b0;
        repeat (45) @(negedge clk);
        expect_val("pre_tmo_flag", S_TMO, 0);
        expect_val("pre_tmo_locked", S_LOCK, 1);
        drain();
        repeat (40) @(negedge clk);
        expect_val("tmo_flag", S_TMO, 1);
        expect_val("tmo_unlocked", S_LOCK, 0);
        expect_val("tmo_plen_hold", S_PLEN, 24);
        drain();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
        expect_val("clr_mm", S_MM, 0);
        expect_val("clr_tmo", S_TMO, 0);
        drain();
        for (int p = 0; p < 7; p++) phase(24);
        settle();
        expect_val("restart_locked", S_LOCK, 1);
        expect_val("restart_plen", S_PLEN, 24);
        expect_val("restart_period", S_PER, 8);
        expect_val("restart_tmo", S_TMO, 0);
        drain();

        // Alternating 16/17 phases never lock
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        en = 1'b1;
        lock_base = n_lock_cyc;
        for (int p = 0; p < 8; p++) phase((p % 2 == 0) ? 16 : 17);
        settle();
        expect_val("alt_lock_cycles", S_NLOCK, 0);
        expect_val("alt_mm", S_MM, 0);
        expect_val("alt_tmo", S_TMO, 0);
        expect_val("alt_period", S_PER, 8);
        drain();

        // Disable mid-VERIFY, then re-enable with 32-bit phases
        en = 1'b0;
        repeat (3) @(negedge clk);
        expect_all_zero("dis");
        drain();
        en = 1'b1;
        for (int p = 0; p < 7; p++) phase(32);
        settle();
        expect_val("lock32_locked", S_LOCK, 1);
        expect_val("lock32_plen", S_PLEN, 32);
        drain();

        // Asynchronous reset while running
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        expect_all_zero("rst_mid");
        drain();
        rstn = 1'b1;

        // Timeout disabled: long SCK stop saturates the period
        cfg_timeout = 16'd0;
        repeat (2) @(negedge clk);
        for (int p = 0; p < 7; p++) phase(16);
        settle();
        expect_val("sat_pre_locked", S_LOCK, 1);
        expect_val("sat_pre_period", S_PER, 8);
        drain();
        @(negedge clk);
        sck = 1'b0;
        repeat (70000) @(negedge clk);
        sck = 1'b1;
        repeat (5) @(negedge clk);
        expect_val("sat_period", S_PER, 32'hFFFF);
        expect_val("sat_tmo", S_TMO, 0);
        expect_val("sat_locked", S_LOCK, 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
